// File: rtl/tt_sweep_checker_if.sv
// Handshake and result bundle between a sweep driver and the truth-table checker.
interface tt_sweep_checker_if;
  logic       start;
  logic [3:0] expected;
  logic       dut_s;
  logic       p;
  logic       q;
  logic       busy;
  logic       done;
  logic [3:0] code;
  logic       match;
  logic [1:0] bad_row;

  modport master (output start, expected, dut_s,
                  input  p, q, busy, done, code, match, bad_row);
  modport slave  (input  start, expected, dut_s,
                  output p, q, busy, done, code, match, bad_row);
endinterface

// File: rtl/tt_sweep_checker.sv
// Drives all four {p,q} rows into a 2-input combinational DUT, captures its
// truth table and compares it against a golden table latched at start.
module tt_sweep_checker #(
  parameter int unsigned SETTLE_CYC = 1
) (
  input logic             clk,
  input logic             rst_n,
  tt_sweep_checker_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SETTLE, DONE} state_t;

  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYC);

  state_t     state_q, state_d;
  logic [1:0] row_q, row_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] pq_q, pq_d;
  logic [3:0] exp_q, exp_d;
  logic [3:0] code_q, code_d;
  logic       match_q, match_d;
  logic [1:0] bad_q, bad_d;
  logic [3:0] code_nxt;
  logic       sample;
  logic       busy, done;

  function automatic logic [1:0] lowest_set(input logic [3:0] v);
    if (v[0])      return 2'd0;
    else if (v[1]) return 2'd1;
    else if (v[2]) return 2'd2;
    else if (v[3]) return 2'd3;
    else           return 2'd0;
  endfunction

  // Sample edge: the settle counter would reach zero on this edge.
  assign sample = (state_q == SETTLE) && (cnt_q == 4'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = SETTLE;
      SETTLE:  if (sample && row_q == 2'd3) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != IDLE);
    done = (state_q == DONE);
  end

  always_comb begin
    row_d    = row_q;
    cnt_d    = cnt_q;
    pq_d     = pq_q;
    exp_d    = exp_q;
    code_d   = code_q;
    match_d  = match_q;
    bad_d    = bad_q;
    code_nxt = code_q;
    code_nxt[row_q] = bus.dut_s;
    case (state_q)
      IDLE: begin
        pq_d  = 2'b00;
        row_d = 2'd0;
        cnt_d = 4'd0;
        if (bus.start) begin
          exp_d   = bus.expected;
          code_d  = 4'b0000;
          match_d = 1'b0;
          bad_d   = 2'd0;
          cnt_d   = SETTLE_INIT;
        end
      end
      SETTLE: begin
        if (sample) begin
          code_d = code_nxt;
          if (row_q == 2'd3) begin
            // Result is judged on the table including the bit just sampled.
            pq_d    = 2'b00;
            cnt_d   = 4'd0;
            match_d = (code_nxt == exp_q);
            bad_d   = lowest_set(code_nxt ^ exp_q);
          end else begin
            row_d = row_q + 2'd1;
            pq_d  = row_q + 2'd1;
            cnt_d = SETTLE_INIT;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q   <= 2'd0;
      cnt_q   <= 4'd0;
      pq_q    <= 2'b00;
      exp_q   <= 4'b0000;
      code_q  <= 4'b0000;
      match_q <= 1'b0;
      bad_q   <= 2'd0;
    end else begin
      row_q   <= row_d;
      cnt_q   <= cnt_d;
      pq_q    <= pq_d;
      exp_q   <= exp_d;
      code_q  <= code_d;
      match_q <= match_d;
      bad_q   <= bad_d;
    end
  end

  assign bus.p       = pq_q[1];
  assign bus.q       = pq_q[0];
  assign bus.busy    = busy;
  assign bus.done    = done;
  assign bus.code    = code_q;
  assign bus.match   = match_q;
  assign bus.bad_row = bad_q;
endmodule
